// File: rtl/park_gate_sequencer.sv
// park_gate_sequencer: debounces the two barrier beams and classifies complete
// passes as entries or exits, while tracking a saturating occupancy count.
// Ports: clk/rst (sync, active-high); sensor_a/sensor_b raw beams (1 = blocked);
//   entry_pulse/exit_pulse/reject_pulse one-cycle events; gate_open barrier request;
//   full, occupancy[3:0], underflow (sticky) status. All outputs registered.
module park_gate_sequencer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CAPACITY        = 12,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sensor_a,
  input  logic       sensor_b,
  output logic       entry_pulse,
  output logic       exit_pulse,
  output logic       reject_pulse,
  output logic       gate_open,
  output logic       full,
  output logic [3:0] occupancy,
  output logic       underflow
);

  typedef enum logic [2:0] {IDLE, EN1, EN2, EN3, EX1, EX2, EX3, REJ} state_t;

  localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] CAP      = 4'(CAPACITY);

  logic       a_s1, a_s2, b_s1, b_s2;
  logic [3:0] cnt_a, cnt_b, cnt_a_nxt, cnt_b_nxt;
  logic       da, db, da_nxt, db_nxt;
  logic [7:0] tmo;
  state_t     state, state_nxt;

  // Stability filter: a run of samples that differ from the current level is
  // counted; the level flips on the last sample of the run, and any sample that
  // matches the current level restarts the run.
  always_comb begin
    da_nxt    = da;
    db_nxt    = db;
    cnt_a_nxt = '0;
    cnt_b_nxt = '0;
    if (a_s2 != da) begin
      if (cnt_a == DEB_LAST) da_nxt = a_s2;
      else                   cnt_a_nxt = cnt_a + 4'd1;
    end
    if (b_s2 != db) begin
      if (cnt_b == DEB_LAST) db_nxt = b_s2;
      else                   cnt_b_nxt = cnt_b + 4'd1;
    end
  end

  // The FSM looks at the debounced level as it settles on this edge, so the
  // state (and gate_open) moves on the same edge that da/db change.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (da_nxt && !db_nxt)      state_nxt = full ? REJ : EN1;
        else if (db_nxt && !da_nxt) state_nxt = EX1;
      end
      EN1: begin
        if (da_nxt && db_nxt)         state_nxt = EN2;
        else if (!da_nxt && !db_nxt)  state_nxt = IDLE;
      end
      EN2: begin
        if (!da_nxt && db_nxt)        state_nxt = EN3;
        else if (da_nxt && !db_nxt)   state_nxt = EN1;
        else if (!da_nxt && !db_nxt)  state_nxt = IDLE;
      end
      EN3: begin
        if (!da_nxt && !db_nxt)       state_nxt = IDLE;
        else if (da_nxt && db_nxt)    state_nxt = EN2;
      end
      EX1: begin
        if (da_nxt && db_nxt)         state_nxt = EX2;
        else if (!da_nxt && !db_nxt)  state_nxt = IDLE;
      end
      EX2: begin
        if (da_nxt && !db_nxt)        state_nxt = EX3;
        else if (!da_nxt && db_nxt)   state_nxt = EX1;
        else if (!da_nxt && !db_nxt)  state_nxt = IDLE;
      end
      EX3: begin
        if (!da_nxt && !db_nxt)       state_nxt = IDLE;
        else if (da_nxt && db_nxt)    state_nxt = EX2;
      end
      REJ: begin
        if (!da_nxt && !db_nxt)       state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_s1         <= 1'b0;
      a_s2         <= 1'b0;
      b_s1         <= 1'b0;
      b_s2         <= 1'b0;
      cnt_a        <= '0;
      cnt_b        <= '0;
      da           <= 1'b0;
      db           <= 1'b0;
      state        <= IDLE;
      tmo          <= '0;
      entry_pulse  <= 1'b0;
      exit_pulse   <= 1'b0;
      reject_pulse <= 1'b0;
      gate_open    <= 1'b0;
      full         <= 1'b0;
      occupancy    <= '0;
      underflow    <= 1'b0;
    end else begin
      a_s1         <= sensor_a;
      a_s2         <= a_s1;
      b_s1         <= sensor_b;
      b_s2         <= b_s1;
      cnt_a        <= cnt_a_nxt;
      cnt_b        <= cnt_b_nxt;
      da           <= da_nxt;
      db           <= db_nxt;
      entry_pulse  <= 1'b0;
      exit_pulse   <= 1'b0;
      reject_pulse <= 1'b0;
      // full lags occupancy by one cycle.
      full         <= (occupancy == CAP);

      if (state_nxt != state) begin
        state     <= state_nxt;
        tmo       <= '0;
        gate_open <= (state_nxt != IDLE) && (state_nxt != REJ);
        if (state == EN3 && state_nxt == IDLE) begin
          entry_pulse <= 1'b1;
          if (occupancy != CAP) occupancy <= occupancy + 4'd1;
        end
        if (state == EX3 && state_nxt == IDLE) begin
          exit_pulse <= 1'b1;
          if (occupancy != 4'd0) occupancy <= occupancy - 4'd1;
          else                   underflow <= 1'b1;
        end
        if (state == REJ && state_nxt == IDLE) reject_pulse <= 1'b1;
      end else if (state != IDLE) begin
        // Stuck pass: drop back to IDLE silently.
        if (tmo == TMO_LAST) begin
          state     <= IDLE;
          tmo       <= '0;
          gate_open <= 1'b0;
        end else begin
          tmo <= tmo + 8'd1;
        end
      end
    end
  end

endmodule
